// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: two-flop line synchronizer, centre-sampling
// frame FSM with optional parity and 1/2 stop bits, break detection, and a
// first-word-fall-through receive FIFO with a sticky overrun flag.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic                 i_RX_Serial,
    input  logic                 i_RX_Ready,
    input  logic                 i_Ovr_Clr,
    output logic                 o_RX_Valid,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Overrun,
    output logic                 o_Break
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = AW + 1;
    localparam int          EW        = DATA_BITS + 2;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF      = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    logic                 sync1_q, sync2_q;
    logic [1:0]           settle_q;
    logic                 armed_q;
    state_t               state_q;
    logic [15:0]          cnt_q;
    logic [2:0]           idx_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 par_bit_q, par_err_q, ferr_q, stop_idx_q, break_q;

    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 ovr_q;

    logic                 bit_tick, all_zero_d, last_stop_d, frame_err_d;
    logic                 is_break_d, fifo_wr_d, full, pop, push, ovr_evt;
    logic [EW-1:0]        entry_d, head;

    // Parity check of a received word against its parity bit.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        if (PARITY == 1) return (x != 1'b1);
        else             return (x != 1'b0);
    endfunction

    // Two-flop synchronizer; arming waits until a real idle-high line has been seen
    // after reset so a line held low across reset cannot start a frame.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            settle_q <= 2'b00;
            armed_q  <= 1'b0;
        end else begin
            sync1_q  <= i_RX_Serial;
            sync2_q  <= sync1_q;
            settle_q <= {settle_q[0], 1'b1};
            if (settle_q[1] && sync2_q) armed_q <= 1'b1;
        end
    end

    // Stop-bit decisions: break, framing error and the FIFO write strobe.
    always_comb begin
        bit_tick    = (cnt_q == BIT_LAST);
        all_zero_d  = (data_q == '0) && ((PARITY == 0) || !par_bit_q) && !sync2_q;
        last_stop_d = (STOP_BITS == 1) || stop_idx_q;
        frame_err_d = ferr_q | ~sync2_q;
        is_break_d  = (state_q == S_STOP) && bit_tick && !stop_idx_q && all_zero_d;
        fifo_wr_d   = (state_q == S_STOP) && bit_tick && last_stop_d && !is_break_d;
        entry_d     = {data_q, par_err_q, frame_err_d};
    end

    // Receive FSM: start validation, LSB-first data shift, parity, stop bits.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
            ferr_q     <= 1'b0;
            stop_idx_q <= 1'b0;
            break_q    <= 1'b0;
        end else begin
            break_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q      <= '0;
                    idx_q      <= '0;
                    par_bit_q  <= 1'b0;
                    par_err_q  <= 1'b0;
                    ferr_q     <= 1'b0;
                    stop_idx_q <= 1'b0;
                    if (armed_q && !sync2_q) state_q <= S_START;
                end
                S_START: begin
                    if (cnt_q == HALF) begin
                        cnt_q   <= '0;
                        state_q <= sync2_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        cnt_q  <= '0;
                        data_q <= {sync2_q, data_q[DATA_BITS-1:1]};
                        if (idx_q == DATA_LAST) begin
                            idx_q   <= '0;
                            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_PARITY: begin
                    if (bit_tick) begin
                        cnt_q     <= '0;
                        par_bit_q <= sync2_q;
                        par_err_q <= parity_bad(data_q, sync2_q);
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        cnt_q <= '0;
                        if (is_break_d) begin
                            break_q <= 1'b1;
                            state_q <= S_WAIT_HIGH;
                        end else if (fifo_wr_d) begin
                            state_q <= frame_err_d ? S_WAIT_HIGH : S_IDLE;
                        end else begin
                            ferr_q     <= frame_err_d;
                            stop_idx_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_WAIT_HIGH: begin
                    cnt_q <= '0;
                    if (sync2_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign full = (count_q == CW'(FIFO_DEPTH));
    assign pop  = o_RX_Valid && i_RX_Ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push    = fifo_wr_d && (!full || pop);
    assign ovr_evt = fifo_wr_d && full && !pop;

    // FIFO storage array.
    always_ff @(posedge i_Clock) begin
        if (push) mem_q[wr_ptr_q] <= entry_d;
    end

    // FIFO pointers, occupancy and the sticky overrun flag.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (ovr_evt)        ovr_q <= 1'b1;
            else if (i_Ovr_Clr) ovr_q <= 1'b0;
        end
    end

    // Head fields are forced to zero while the FIFO is empty.
    assign head         = mem_q[rd_ptr_q];
    assign o_RX_Valid   = (count_q != '0);
    assign o_RX_Byte    = o_RX_Valid ? head[EW-1:2] : '0;
    assign o_Parity_Err = o_RX_Valid & head[1];
    assign o_Frame_Err  = o_RX_Valid & head[0];
    assign o_Overrun    = ovr_q;
    assign o_Break      = break_q;

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, clock cycles per serial bit (legal range 4..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal range 5..8).
REQ-003 SHALL have parameter PARITY, default 0, parity mode (0 none, 1 odd, 2 even).
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal values 1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of 2, 2..64).
REQ-006 SHALL have port i_Clock, input, 1, the single clock; all logic sits on its rising edge.
REQ-007 SHALL have port i_Reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_RX_Serial, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port i_RX_Ready, input, 1, consumer accepts the FIFO head entry.
REQ-010 SHALL have port i_Ovr_Clr, input, 1, synchronous clear of o_Overrun.
REQ-011 SHALL have port o_RX_Valid, output, 1, FIFO non-empty (head entry is valid).
REQ-012 SHALL have port o_RX_Byte, output, DATA_BITS, head entry data, LSB = first bit received.
REQ-013 SHALL have port o_Parity_Err, output, 1, head entry parity-error flag.
REQ-014 SHALL have port o_Frame_Err, output, 1, head entry framing-error flag.
REQ-015 SHALL have port o_Overrun, output, 1, sticky flag: a frame was dropped because the FIFO was full.
REQ-016 SHALL have port o_Break, output, 1, one-cycle pulse when a break condition is detected.

Function
REQ-017 SHALL pass i_RX_Serial through a two-flop synchronizer; both flops reset to 1; all line decisions use the second flop output.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-019 IDLE: clear bit counter and bit index; go to START when the synchronized line = 0.
REQ-020 START: count to (CLKS_PER_BIT-1)/2, then sample; 0 goes to DATA with counter cleared; 1 (glitch) returns to IDLE with no FIFO write.
REQ-021 DATA: sample each bit after CLKS_PER_BIT cycles, store LSB first; after DATA_BITS samples go to PARITY if PARITY != 0, else STOP.
REQ-022 PARITY: sample after CLKS_PER_BIT cycles; parity error = XOR(data, parity bit) != 1 for odd, != 0 for even; then go to STOP.
REQ-023 STOP: sample STOP_BITS stop bits, each CLKS_PER_BIT cycles apart; framing error if any sampled stop bit = 0.
REQ-024 Break = all data bits, the parity bit (if present) and the first stop bit all sampled 0; on break, pulse o_Break for one cycle, write no FIFO entry, go to WAIT_HIGH.
REQ-025 Non-break frame: on the edge that samples the final stop bit, write {data, parity err, frame err} to the FIFO; next state = WAIT_HIGH if frame err, else IDLE.
REQ-026 With STOP_BITS = 2 and a first stop bit of 0 (not a break), SHALL still sample the second stop bit before writing the entry.
REQ-027 WAIT_HIGH: stay until the synchronized line = 1, then go to IDLE; no start detection while in this state.
REQ-028 FIFO SHALL be first-word-fall-through; o_RX_Valid = not empty; head fields are valid whenever o_RX_Valid = 1.
REQ-029 Pop occurs on an edge with o_RX_Valid = 1 and i_RX_Ready = 1; i_RX_Ready while empty has no effect.
REQ-030 Write while full and no pop in the same cycle: drop the frame, set o_Overrun, leave FIFO contents unchanged.
REQ-031 Write while full with a pop in the same cycle: accept the write, no overrun; write and pop on a non-full FIFO leave the count unchanged.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be log2(FIFO_DEPTH)+1.
REQ-033 o_Overrun SHALL clear on i_Ovr_Clr = 1; a simultaneous overrun event takes priority, so the flag stays set.
REQ-034 Bit counter SHALL be 16 bits wide and SHALL never exceed CLKS_PER_BIT-1.

Reset
REQ-035 While i_Reset_n = 0, asynchronously: state IDLE, counters 0, FIFO empty, synchronizer = 1, o_RX_Valid = 0, o_Overrun = 0, o_Break = 0; o_RX_Byte, o_Parity_Err and o_Frame_Err = 0.
REQ-036 Reset mid-frame SHALL discard the partial frame; after release, the line must show a fresh falling edge before any new start is detected.

Verification (CLKS_PER_BIT = 16, FIFO_DEPTH = 4)
REQ-037 8N1 frame 0xA5, i_RX_Ready = 1 -> one entry 0xA5, both error flags 0; o_RX_Valid high exactly one cycle.
REQ-038 PARITY = 2, frame 0x03 with parity bit 1 -> entry 0x03 with o_Parity_Err = 1; with parity bit 0 -> o_Parity_Err = 0.
REQ-039 Stop bit driven 0, then line high -> entry with o_Frame_Err = 1; FSM stays in WAIT_HIGH until the line returns high.
REQ-040 Line low for 12 bit times -> single o_Break pulse, no entry, no start detected until the line returns high.
REQ-041 i_RX_Ready = 0, 5 frames 0x01..0x05 -> FIFO holds 0x01..0x04, o_Overrun = 1; pops return that order; i_Ovr_Clr clears the flag.
REQ-042 Start pulse low for 6 clocks -> no entry; assert reset halfway through a frame -> FIFO empty and all outputs 0 after release.
